voxel_gpu_fill: RTL and testbench

- Parametrised successor to the voxel GPU control block: same Avalon-MM slave register file (buffers, voxel count, camera), plus a working master-side frame-fill engine.
- A write to the trigger register fills an H_RESOLUTION x V_RESOLUTION region of the pixel buffer with a programmable colour over m1, one pixel per write.
- Status register and a maskable level interrupt report completion.
- Sits between the HPS lightweight bridge (s1) and SDRAM/on-chip pixel memory (m1).

---
 rtl/voxel_gpu_pkg.sv | 45 ++++
 rtl/voxel_fill_engine.sv | 142 ++++++++++++++
 rtl/voxel_gpu_fill.sv | 166 ++++++++++++++++
 tb/tb_voxel_gpu_fill.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/voxel_gpu_pkg.sv
// Shared types and constants for the voxel GPU control block and its fill engine.
package voxel_gpu_pkg;

  // Camera vectors as held by the register file.
  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
  } vec3_t;

  typedef struct packed {
    vec3_t pos;
    vec3_t look0;
    vec3_t look1;
    vec3_t look2;
  } camera_t;

  // Slave register word addresses.
  localparam logic [7:0] REG_PIXEL_BUFFER = 8'h00;
  localparam logic [7:0] REG_VOXEL_BUFFER = 8'h01;
  localparam logic [7:0] REG_VOXEL_COUNT  = 8'h02;
  localparam logic [7:0] REG_CLEAR_COLOR  = 8'h03;
  localparam logic [7:0] REG_STATUS       = 8'h04;
  localparam logic [7:0] REG_IRQ_ENABLE   = 8'h05;
  localparam logic [7:0] REG_FILL_CYCLES  = 8'h06;
  localparam logic [7:0] REG_TRIGGER      = 8'h0F;
  localparam logic [7:0] REG_CAM_BASE     = 8'h10;
  localparam int         CAM_WORDS        = 12;

  // Status register bit positions.
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

  // Fill engine states.
  typedef enum logic [0:0] {
    FILL_IDLE  = 1'b0,
    FILL_WRITE = 1'b1
  } fill_state_e;

  // True when a word address falls inside the camera register window.
  function automatic logic is_cam_addr(input logic [7:0] addr);
    return (addr[7:4] == REG_CAM_BASE[7:4]) && (addr[3:0] < 4'd12);
  endfunction

endpackage

// File: rtl/voxel_fill_engine.sv
// Frame-fill engine: walks an H x V pixel region one Avalon-MM write per
// pixel, holding address/data stable through waitrequest stalls. Addresses are
// produced incrementally (pixel step within a row, row stride between rows).
module voxel_fill_engine
  import voxel_gpu_pkg::*;
#(
  parameter logic [15:0] H_RESOLUTION = 16'd256,
  parameter logic [15:0] V_RESOLUTION = 16'd192,
  parameter int          PIXEL_BYTES  = 2,
  parameter logic [31:0] ROW_STRIDE   = 32'd1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base,
  input  logic [31:0] color,
  input  logic        m1_waitrequest,
  output logic [31:0] m1_address,
  output logic [31:0] m1_writedata,
  output logic        m1_write,
  output logic        busy,
  output logic        done_pulse
);

  localparam logic [31:0] PIXEL_STEP = 32'(PIXEL_BYTES);

  fill_state_e state_r;
  fill_state_e state_next_s;
  logic [15:0] x_r;
  logic [15:0] y_r;
  logic [31:0] row_base_r;
  logic [31:0] addr_r;
  logic [31:0] color_r;
  logic        accept_s;
  logic        last_x_s;
  logic        last_y_s;
  logic        last_pixel_s;

  assign accept_s     = (state_r == FILL_WRITE) && !m1_waitrequest;
  assign last_x_s     = (x_r == (H_RESOLUTION - 16'd1));
  assign last_y_s     = (y_r == (V_RESOLUTION - 16'd1));
  assign last_pixel_s = last_x_s && last_y_s;

  // State register; reset drops any fill in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= FILL_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: start leaves IDLE, the final accepted pixel returns.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      FILL_IDLE: begin
        if (start) begin
          state_next_s = FILL_WRITE;
        end else begin
          state_next_s = FILL_IDLE;
        end
      end
      FILL_WRITE: begin
        if (accept_s && last_pixel_s) begin
          state_next_s = FILL_IDLE;
        end else begin
          state_next_s = FILL_WRITE;
        end
      end
      default: state_next_s = FILL_IDLE;
    endcase
  end

  // Outputs decoded from the state register only, so m1_write never glitches.
  always_comb begin
    m1_write   = 1'b0;
    busy       = 1'b0;
    done_pulse = 1'b0;
    case (state_r)
      FILL_WRITE: begin
        m1_write   = 1'b1;
        busy       = 1'b1;
        done_pulse = accept_s && last_pixel_s;
      end
      FILL_IDLE: begin
        m1_write   = 1'b0;
        busy       = 1'b0;
        done_pulse = 1'b0;
      end
      default: begin
        m1_write   = 1'b0;
        busy       = 1'b0;
        done_pulse = 1'b0;
      end
    endcase
  end

  // Snapshot on start, then advance pixel/row counters and address per accept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_r        <= 16'd0;
      y_r        <= 16'd0;
      row_base_r <= 32'h0000_0000;
      addr_r     <= 32'h0000_0000;
      color_r    <= 32'h0000_0000;
    end else begin
      case (state_r)
        FILL_IDLE: begin
          if (start) begin
            x_r        <= 16'd0;
            y_r        <= 16'd0;
            row_base_r <= base;
            addr_r     <= base;
            color_r    <= color;
          end
        end
        FILL_WRITE: begin
          if (accept_s && !last_pixel_s) begin
            if (last_x_s) begin
              x_r        <= 16'd0;
              y_r        <= y_r + 16'd1;
              row_base_r <= row_base_r + ROW_STRIDE;
              addr_r     <= row_base_r + ROW_STRIDE;
            end else begin
              x_r    <= x_r + 16'd1;
              addr_r <= addr_r + PIXEL_STEP;
            end
          end
        end
        default: begin
          x_r <= 16'd0;
          y_r <= 16'd0;
        end
      endcase
    end
  end

  assign m1_address   = addr_r;
  assign m1_writedata = color_r;

endmodule

// File: rtl/voxel_gpu_fill.sv
// Voxel GPU control block with frame-fill engine.
// s1: register file (buffers, voxel count, camera, status, irq enable, trigger).
// m1: pixel writes issued by voxel_fill_engine.
// Optional build macro VOXEL_GPU_PERF_EN adds the read-only fill_cycles
// counter at word address 06; without it that address reads 0.
module voxel_gpu_fill
  import voxel_gpu_pkg::*;
#(
  parameter logic [31:0] DEFAULT_BUFFER = 32'h0800_0000,
  parameter logic [15:0] H_RESOLUTION   = 16'd256,
  parameter logic [15:0] V_RESOLUTION   = 16'd192,
  parameter int          PIXEL_BYTES    = 2,
  parameter logic [31:0] ROW_STRIDE     = 32'd1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  s1_address,
  output logic [31:0] s1_readdata,
  input  logic [31:0] s1_writedata,
  input  logic        s1_write,
  output logic        s1_waitrequest,
  output logic        irq,
  output logic [31:0] m1_address,
  output logic [31:0] m1_writedata,
  output logic        m1_write,
  input  logic        m1_waitrequest,
  input  logic [31:0] m1_readdata,
  output logic        m1_read,
  input  logic        m1_readdatavalid
);

  logic [31:0] pixel_buffer_r;
  logic [31:0] voxel_buffer_r;
  logic [31:0] voxel_count_r;
  logic [31:0] clear_color_r;
  logic        irq_enable_r;
  logic        done_r;
  logic [31:0] cam_r [CAM_WORDS];
  logic [31:0] readdata_s;
  logic [3:0]  cam_idx_s;
  logic        cam_sel_s;
  logic        busy_s;
  logic        done_pulse_s;
  logic        trigger_s;
  logic        start_s;
  logic        done_clear_s;
  logic        unused_s;

  assign cam_idx_s    = s1_address[3:0];
  assign cam_sel_s    = is_cam_addr(s1_address);
  assign trigger_s    = s1_write && (s1_address == REG_TRIGGER);
  assign start_s      = trigger_s && !busy_s;
  assign done_clear_s = s1_write && (s1_address == REG_STATUS) && s1_writedata[STATUS_DONE_BIT];

  assign s1_waitrequest = 1'b0;
  assign m1_read        = 1'b0;
  assign irq            = done_r & irq_enable_r;
  assign unused_s       = ^{m1_readdata, m1_readdatavalid};

  // Scalar register file writes; take effect immediately even while filling.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pixel_buffer_r <= DEFAULT_BUFFER;
      voxel_buffer_r <= 32'h0000_0000;
      voxel_count_r  <= 32'h0000_0000;
      clear_color_r  <= 32'h0000_0000;
      irq_enable_r   <= 1'b0;
    end else if (s1_write) begin
      case (s1_address)
        REG_PIXEL_BUFFER: pixel_buffer_r <= s1_writedata;
        REG_VOXEL_BUFFER: voxel_buffer_r <= s1_writedata;
        REG_VOXEL_COUNT:  voxel_count_r  <= s1_writedata;
        REG_CLEAR_COLOR:  clear_color_r  <= s1_writedata;
        REG_IRQ_ENABLE:   irq_enable_r   <= s1_writedata[0];
        default: ;
      endcase
    end
  end

  // Camera register window writes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CAM_WORDS; i++) begin
        cam_r[i] <= 32'h0000_0000;
      end
    end else if (s1_write && cam_sel_s) begin
      cam_r[cam_idx_s] <= s1_writedata;
    end
  end

  // Sticky done: completion has priority over both clear sources.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done_r <= 1'b0;
    end else if (done_pulse_s) begin
      done_r <= 1'b1;
    end else if (start_s || done_clear_s) begin
      done_r <= 1'b0;
    end else begin
      done_r <= done_r;
    end
  end

`ifdef VOXEL_GPU_PERF_EN
  logic [31:0] fill_cycles_r;

  // Busy-cycle counter: cleared on start, saturating, frozen once idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fill_cycles_r <= 32'h0000_0000;
    end else if (start_s) begin
      fill_cycles_r <= 32'h0000_0000;
    end else if (busy_s && (fill_cycles_r != 32'hFFFF_FFFF)) begin
      fill_cycles_r <= fill_cycles_r + 32'd1;
    end
  end
`endif

  // Combinational read mux; unmapped and write-only addresses return 0.
  always_comb begin
    readdata_s = 32'h0000_0000;
    case (s1_address)
      REG_PIXEL_BUFFER: readdata_s = pixel_buffer_r;
      REG_VOXEL_BUFFER: readdata_s = voxel_buffer_r;
      REG_VOXEL_COUNT:  readdata_s = voxel_count_r;
      REG_CLEAR_COLOR:  readdata_s = clear_color_r;
      REG_STATUS: begin
        readdata_s[STATUS_BUSY_BIT] = busy_s;
        readdata_s[STATUS_DONE_BIT] = done_r;
      end
      REG_IRQ_ENABLE:   readdata_s = {31'h0, irq_enable_r};
`ifdef VOXEL_GPU_PERF_EN
      REG_FILL_CYCLES:  readdata_s = fill_cycles_r;
`endif
      default: begin
        if (cam_sel_s) begin
          readdata_s = cam_r[cam_idx_s];
        end else begin
          readdata_s = 32'h0000_0000;
        end
      end
    endcase
  end

  assign s1_readdata = readdata_s;

  voxel_fill_engine #(
    .H_RESOLUTION (H_RESOLUTION),
    .V_RESOLUTION (V_RESOLUTION),
    .PIXEL_BYTES  (PIXEL_BYTES),
    .ROW_STRIDE   (ROW_STRIDE)
  ) u_fill_engine (
    .clock          (clock),
    .reset          (reset),
    .start          (start_s),
    .base           (pixel_buffer_r),
    .color          (clear_color_r),
    .m1_waitrequest (m1_waitrequest),
    .m1_address     (m1_address),
    .m1_writedata   (m1_writedata),
    .m1_write       (m1_write),
    .busy           (busy_s),
    .done_pulse     (done_pulse_s)
  );

endmodule

// File: tb/tb_voxel_gpu_fill.sv
// Directed self-checking bench for voxel_gpu_fill (4x2 region, 2-byte pixels,
// 16-byte row stride). Inputs change 1ns after the rising edge; the m1 bus is
// observed on the falling edge.
module tb_voxel_gpu_fill;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  s1_address = 8'h00;
  logic [31:0] s1_writedata = 32'h0;
  logic        s1_write = 1'b0;
  logic [31:0] s1_readdata;
  logic        s1_waitrequest;
  logic        irq;
  logic [31:0] m1_address;
  logic [31:0] m1_writedata;
  logic        m1_write;
  logic        m1_waitrequest = 1'b0;
  logic [31:0] m1_readdata = 32'h0;
  logic        m1_read;
  logic        m1_readdatavalid = 1'b0;

  int checks = 0;
  int errors = 0;

  // Hand-computed byte offsets of the 8 pixels for a 4x2 fill, stride 16.
  logic [31:0] exp_off [8] = '{32'h00, 32'h02, 32'h04, 32'h06,
                               32'h10, 32'h12, 32'h14, 32'h16};

`ifdef VOXEL_GPU_PERF_EN
  localparam logic [31:0] PERF_NOSTALL = 32'd8;
  localparam logic [31:0] PERF_STALL   = 32'd14;
`else
  localparam logic [31:0] PERF_NOSTALL = 32'd0;
  localparam logic [31:0] PERF_STALL   = 32'd0;
`endif

  voxel_gpu_fill #(
    .DEFAULT_BUFFER (32'h0800_0000),
    .H_RESOLUTION   (16'd4),
    .V_RESOLUTION   (16'd2),
    .PIXEL_BYTES    (2),
    .ROW_STRIDE     (32'd16)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .s1_address       (s1_address),
    .s1_readdata      (s1_readdata),
    .s1_writedata     (s1_writedata),
    .s1_write         (s1_write),
    .s1_waitrequest   (s1_waitrequest),
    .irq              (irq),
    .m1_address       (m1_address),
    .m1_writedata     (m1_writedata),
    .m1_write         (m1_write),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_read          (m1_read),
    .m1_readdatavalid (m1_readdatavalid)
  );

  always #5 clock = ~clock;

  // Bus monitor: log accepted writes, count stalls and instability.
  logic [31:0] acc_addr [128];
  logic [31:0] acc_data [128];
  int          acc_cnt = 0;
  int          hi_cycles = 0;
  int          stall_cycles = 0;
  int          stall_bad = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] prev_data = 32'h0;

  always @(negedge clock) begin
    if (m1_write === 1'b1) begin
      hi_cycles++;
      if (prev_stall && (m1_address !== prev_addr || m1_writedata !== prev_data)) stall_bad++;
      if (m1_waitrequest) begin
        stall_cycles++;
      end else begin
        acc_addr[acc_cnt % 128] = m1_address;
        acc_data[acc_cnt % 128] = m1_writedata;
        acc_cnt++;
      end
      prev_stall = m1_waitrequest;
      prev_addr  = m1_address;
      prev_data  = m1_writedata;
    end else begin
      if (prev_stall) stall_bad++;
      prev_stall = 1'b0;
    end
  end

  // Waitrequest driver: 3 stall cycles on the 2nd and 5th pixel of a fill.
  logic stall_en = 1'b0;
  int   stall_base = 0;
  int   stall_seen = -1;
  int   stall_n = 0;

  always @(posedge clock) begin
    #1;
    if (stall_en && m1_write === 1'b1 &&
        ((acc_cnt - stall_base) == 1 || (acc_cnt - stall_base) == 4)) begin
      if (stall_seen != acc_cnt) begin
        stall_seen = acc_cnt;
        stall_n    = 0;
      end
      if (stall_n < 3) begin
        m1_waitrequest = 1'b1;
        stall_n++;
      end else begin
        m1_waitrequest = 1'b0;
      end
    end else begin
      m1_waitrequest = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic s1_wr(input logic [7:0] a, input logic [31:0] d);
    s1_address   = a;
    s1_writedata = d;
    s1_write     = 1'b1;
    tick();
    s1_write     = 1'b0;
    s1_address   = 8'h00;
  endtask

  task automatic s1_rd(input logic [7:0] a, output logic [31:0] d);
    s1_address = a;
    #1;
    d = s1_readdata;
    s1_address = 8'h00;
  endtask

  // Bounded wait for busy to drop; an expired budget is a failed comparison.
  task automatic wait_idle(input string tag);
    logic [31:0] st;
    st = 32'h1;
    for (int i = 0; i < 100; i++) begin
      tick();
      s1_rd(8'h04, st);
      if (st[0] == 1'b0) break;
    end
    checks++;
    if (st[0] !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_timeout status=%h want busy=0", tag, st);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    #1 reset = 1'b1;
    repeat (3) tick();
    checks++; if (m1_write !== 1'b0) begin errors++; $display("FAIL rst_m1_write_in_reset got=%b want=0", m1_write); end
    reset = 1'b0;
    tick();
    s1_rd(8'h00, d);
    checks++; if (d !== 32'h0800_0000) begin errors++; $display("FAIL rst_pixel_buffer got=%h want=08000000", d); end
    s1_rd(8'h04, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_status got=%h want=0", d); end
    s1_rd(8'h01, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_voxel_buffer got=%h want=0", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got=%b want=0", irq); end
    checks++; if (m1_write !== 1'b0 || m1_address !== 32'h0 || m1_writedata !== 32'h0) begin
      errors++; $display("FAIL rst_m1 write=%b addr=%h data=%h want 0/0/0", m1_write, m1_address, m1_writedata); end
    checks++; if (s1_waitrequest !== 1'b0 || m1_read !== 1'b0) begin
      errors++; $display("FAIL rst_constants waitreq=%b read=%b want 0/0", s1_waitrequest, m1_read); end
    s1_wr(8'h03, 32'h1234_5678);
    s1_rd(8'h03, d);
    checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL rw_clear_color got=%h want=12345678", d); end
    s1_wr(8'h1B, 32'h1234_5678);
    s1_rd(8'h1B, d);
    checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL rw_cam_1b got=%h want=12345678", d); end
    s1_rd(8'h1A, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rw_cam_1a got=%h want=0", d); end
    s1_wr(8'h3F, 32'hDEAD_BEEF);
    s1_rd(8'h3F, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_3f got=%h want=0", d); end
    s1_rd(8'h0F, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL trigger_reads0 got=%h want=0", d); end
    checks++; if (m1_write !== 1'b0) begin errors++; $display("FAIL no_fill_from_writes got=%b want=0", m1_write); end
  endtask

  task automatic test_fill_nostall();
    logic [31:0] d;
    int b;
    s1_wr(8'h00, 32'h0000_1000);
    s1_wr(8'h03, 32'h0000_F800);
    b = acc_cnt;
    s1_wr(8'h0F, 32'h1);
    checks++; if (m1_write !== 1'b1 || m1_address !== 32'h1000 || m1_writedata !== 32'hF800) begin
      errors++; $display("FAIL fill_first write=%b addr=%h data=%h want 1/1000/f800", m1_write, m1_address, m1_writedata); end
    s1_rd(8'h04, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL fill_busy_start got=%h want=1", d); end
    repeat (7) tick();
    s1_rd(8'h04, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL fill_busy_last got=%h want=1", d); end
    tick();
    s1_rd(8'h04, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL fill_done_latency got=%h want=2", d); end
    checks++; if (acc_cnt - b !== 8) begin errors++; $display("FAIL fill_count got=%0d want=8", acc_cnt - b); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (acc_addr[(b + i) % 128] !== 32'h1000 + exp_off[i] || acc_data[(b + i) % 128] !== 32'hF800) begin
        errors++;
        $display("FAIL fill_pixel%0d addr=%h data=%h want %h/f800", i,
                 acc_addr[(b + i) % 128], acc_data[(b + i) % 128], 32'h1000 + exp_off[i]);
      end
    end
    s1_rd(8'h06, d);
    checks++; if (d !== PERF_NOSTALL) begin errors++; $display("FAIL perf_nostall got=%0d want=%0d", d, PERF_NOSTALL); end
  endtask

  task automatic test_fill_stall();
    logic [31:0] d;
    int b, sc0, hc0, sb0;
    b   = acc_cnt;
    sc0 = stall_cycles;
    hc0 = hi_cycles;
    sb0 = stall_bad;
    stall_base = acc_cnt;
    stall_en   = 1'b1;
    s1_wr(8'h0F, 32'h1);
    s1_rd(8'h04, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL stall_start_status got=%h want=1", d); end
    wait_idle("stall");
    stall_en = 1'b0;
    s1_rd(8'h04, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL stall_done got=%h want=2", d); end
    checks++; if (acc_cnt - b !== 8) begin errors++; $display("FAIL stall_count got=%0d want=8", acc_cnt - b); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (acc_addr[(b + i) % 128] !== 32'h1000 + exp_off[i] || acc_data[(b + i) % 128] !== 32'hF800) begin
        errors++;
        $display("FAIL stall_pixel%0d addr=%h data=%h want %h/f800", i,
                 acc_addr[(b + i) % 128], acc_data[(b + i) % 128], 32'h1000 + exp_off[i]);
      end
    end
    checks++; if (stall_cycles - sc0 !== 6) begin errors++; $display("FAIL stall_cycles got=%0d want=6", stall_cycles - sc0); end
    checks++; if (stall_bad - sb0 !== 0) begin errors++; $display("FAIL stall_stability got=%0d want=0", stall_bad - sb0); end
    checks++; if (hi_cycles - hc0 !== 14) begin errors++; $display("FAIL stall_no_gaps got=%0d want=14", hi_cycles - hc0); end
    s1_rd(8'h06, d);
    checks++; if (d !== PERF_STALL) begin errors++; $display("FAIL perf_stall got=%0d want=%0d", d, PERF_STALL); end
  endtask

  task automatic test_irq_and_retrigger();
    logic [31:0] d;
    int b;
    s1_wr(8'h04, 32'h2);
    s1_rd(8'h04, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL w1c_done got=%h want=0", d); end
    s1_wr(8'h05, 32'h1);
    s1_rd(8'h05, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL irq_enable_rb got=%h want=1", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_before_fill got=%b want=0", irq); end
    b = acc_cnt;
    s1_wr(8'h0F, 32'h1);
    tick();
    s1_wr(8'h0F, 32'h1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_during_fill got=%b want=0", irq); end
    wait_idle("irq");
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_on_done got=%b want=1", irq); end
    repeat (3) tick();
    checks++; if (acc_cnt - b !== 8 || m1_write !== 1'b0) begin
      errors++; $display("FAIL retrigger_ignored count=%0d write=%b want 8/0", acc_cnt - b, m1_write); end
    s1_wr(8'h04, 32'h2);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared got=%b want=0", irq); end
  endtask

  task automatic test_done_set_wins();
    logic [31:0] d;
    s1_wr(8'h0F, 32'h1);
    repeat (7) tick();
    s1_wr(8'h04, 32'h2);
    s1_rd(8'h04, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL done_set_wins got=%h want=2", d); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL done_set_wins_irq got=%b want=1", irq); end
    s1_wr(8'h04, 32'h2);
    s1_rd(8'h04, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL done_clear_after got=%h want=0", d); end
    s1_wr(8'h05, 32'h0);
  endtask

  task automatic test_midfill();
    logic [31:0] d;
    int b;
    b = acc_cnt;
    s1_wr(8'h0F, 32'h1);
    for (int i = 0; i < 50; i++) begin
      if (acc_cnt - b >= 3) break;
      tick();
    end
    checks++; if (acc_cnt - b !== 3) begin errors++; $display("FAIL mid_reach3 got=%0d want=3", acc_cnt - b); end
    s1_wr(8'h00, 32'h0000_2000);
    wait_idle("mid");
    checks++; if (acc_cnt - b !== 8) begin errors++; $display("FAIL mid_count got=%0d want=8", acc_cnt - b); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (acc_addr[(b + i) % 128] !== 32'h1000 + exp_off[i]) begin
        errors++;
        $display("FAIL mid_pixel%0d addr=%h want=%h", i, acc_addr[(b + i) % 128], 32'h1000 + exp_off[i]);
      end
    end
    s1_rd(8'h00, d);
    checks++; if (d !== 32'h0000_2000) begin errors++; $display("FAIL mid_pixel_buffer got=%h want=2000", d); end
    // Second fill from the new base, interrupted by reset.
    b = acc_cnt;
    s1_wr(8'h0F, 32'h1);
    for (int i = 0; i < 50; i++) begin
      if (acc_cnt - b >= 3) break;
      tick();
    end
    checks++; if (m1_write !== 1'b1 || m1_address !== 32'h2006) begin
      errors++; $display("FAIL rstfill_pending write=%b addr=%h want 1/2006", m1_write, m1_address); end
    reset = 1'b1;
    #1;
    checks++; if (m1_write !== 1'b0) begin errors++; $display("FAIL rstfill_m1_write got=%b want=0", m1_write); end
    s1_rd(8'h04, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rstfill_status got=%h want=0", d); end
    s1_rd(8'h00, d);
    checks++; if (d !== 32'h0800_0000) begin errors++; $display("FAIL rstfill_pixel_buffer got=%h want=08000000", d); end
    tick();
    reset = 1'b0;
    repeat (4) tick();
    checks++; if (m1_write !== 1'b0 || acc_cnt - b !== 3) begin
      errors++; $display("FAIL rstfill_no_resume write=%b count=%0d want 0/3", m1_write, acc_cnt - b); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill_nostall();
    test_fill_stall();
    test_irq_and_retrigger();
    test_done_set_wins();
    test_midfill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
